mcif_wrr_sched4: RTL and testbench

- Four-client weighted round-robin request scheduler in front of the shared MCIF memory request port.
- Each client presents addr/len requests over valid/ready. The block selects one client, registers the winning request in a single output stage, and tracks per-client outstanding transactions.
- A client at its outstanding limit is masked from arbitration until completions return.

---
 rtl/mcif_sched_pkg.sv | 14 +
 rtl/mcif_rr_pick4.sv | 28 ++
 rtl/mcif_wrr_sched4.sv | 110 +++++++++++
 tb/tb_mcif_wrr_sched4.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mcif_sched_pkg.sv
// Shared types and helpers for the MCIF four-client request scheduler.
// Client index type and the mod-4 rotation step.
package mcif_sched_pkg;

    localparam int NUM_CLT = 4;
    localparam int CLT_IDW = 2;

    typedef logic [CLT_IDW-1:0] clt_id_t;

    function automatic clt_id_t wrap_inc(clt_id_t id);
        return id + clt_id_t'(1);
    endfunction

endpackage

// File: rtl/mcif_rr_pick4.sv
// Rotating-priority picker: first set bit of the eligible mask,
// scanning upward from start with wrap.
module mcif_rr_pick4
    import mcif_sched_pkg::*;
(
    input  logic [NUM_CLT-1:0] eligible,
    input  clt_id_t            start,
    output clt_id_t            idx,
    output logic               found
);

    clt_id_t cand;

    // Walk from the far end back to start so the nearest hit wins.
    always_comb begin
        idx   = start;
        found = 1'b0;
        cand  = start;
        for (int k = NUM_CLT - 1; k >= 0; k--) begin
            cand = start + clt_id_t'(k);
            if (eligible[cand]) begin
                idx   = cand;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mcif_wrr_sched4.sv
// Four-client weighted round-robin scheduler feeding the MCIF request
// port through one registered output stage with outstanding tracking.
module mcif_wrr_sched4
    import mcif_sched_pkg::*;
#(
    parameter int AW       = 32,
    parameter int LW       = 8,
    parameter int WW       = 4,
    parameter int MAX_OUTS = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_CLT*WW-1:0] cfg_weight,
    input  logic [NUM_CLT-1:0]    clt_req_valid,
    output logic [NUM_CLT-1:0]    clt_req_ready,
    input  logic [NUM_CLT*AW-1:0] clt_req_addr,
    input  logic [NUM_CLT*LW-1:0] clt_req_len,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [AW-1:0]         mem_req_addr,
    output logic [LW-1:0]         mem_req_len,
    output logic [CLT_IDW-1:0]    mem_req_id,
    input  logic                  rsp_done_valid,
    input  logic [CLT_IDW-1:0]    rsp_done_id,
    output logic [NUM_CLT-1:0]    outs_full,
    output logic                  err_underflow
);

    localparam int CW = $clog2(MAX_OUTS + 1);

    logic [CW-1:0] cnt [NUM_CLT];
    logic [WW-1:0] wt [NUM_CLT];
    logic [AW-1:0] addr_v [NUM_CLT];
    logic [LW-1:0] len_v [NUM_CLT];

    logic [NUM_CLT-1:0] eligible;
    logic [NUM_CLT-1:0] inc;
    logic [NUM_CLT-1:0] dec;

    clt_id_t       cur_id;
    clt_id_t       sel;
    clt_id_t       pick_idx;
    logic [WW-1:0] credit;
    logic          pick_found;
    logic          hold;
    logic          any_elig;
    logic          load_en;
    logic          hs;

    for (genvar i = 0; i < NUM_CLT; i++) begin : g_clt
        assign wt[i]        = cfg_weight[i*WW +: WW];
        assign addr_v[i]    = clt_req_addr[i*AW +: AW];
        assign len_v[i]     = clt_req_len[i*LW +: LW];
        assign eligible[i]  = clt_req_valid[i] & (cnt[i] < CW'(MAX_OUTS));
        assign outs_full[i] = (cnt[i] == CW'(MAX_OUTS));
        assign inc[i]       = hs & (sel == clt_id_t'(i));
        assign dec[i]       = rsp_done_valid & (rsp_done_id == clt_id_t'(i));
    end

    mcif_rr_pick4 u_pick (
        .eligible (eligible),
        .start    (wrap_inc(cur_id)),
        .idx      (pick_idx),
        .found    (pick_found)
    );

    assign load_en  = !mem_req_valid | mem_req_ready;
    assign hold     = eligible[cur_id] & (credit != '0);
    assign sel      = hold ? cur_id : pick_idx;
    assign any_elig = hold | pick_found;
    assign hs       = load_en & any_elig;

    assign clt_req_ready = hs ? (NUM_CLT'(1) << sel) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_req_valid <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_len   <= '0;
            mem_req_id    <= '0;
            cur_id        <= clt_id_t'(NUM_CLT - 1);
            credit        <= '0;
            err_underflow <= 1'b0;
            for (int i = 0; i < NUM_CLT; i++) cnt[i] <= '0;
        end else begin
            if (load_en) mem_req_valid <= hs;
            if (hs) begin
                mem_req_addr <= addr_v[sel];
                mem_req_len  <= len_v[sel];
                mem_req_id   <= sel;
                if (hold) begin
                    credit <= credit - WW'(1);
                end else begin
                    cur_id <= sel;
                    credit <= (wt[sel] == '0) ? '0 : wt[sel] - WW'(1);
                end
            end
            // Issue and completion on one client in a cycle cancel out.
            for (int i = 0; i < NUM_CLT; i++) begin
                if (inc[i] && !dec[i]) begin
                    cnt[i] <= cnt[i] + CW'(1);
                end else if (dec[i] && !inc[i]) begin
                    if (cnt[i] == '0) err_underflow <= 1'b1;
                    else cnt[i] <= cnt[i] - CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_mcif_wrr_sched4.sv
// Directed bench for mcif_wrr_sched4 with a queue-based request scoreboard.
module tb_mcif_wrr_sched4;
    import mcif_sched_pkg::*;

    localparam int AW = 32;
    localparam int LW = 8;
    localparam int WW = 4;
    localparam int MO = 8;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [NUM_CLT*WW-1:0] cfg_weight = 16'h1111;
    logic [NUM_CLT-1:0]    clt_req_valid = '0;
    logic [NUM_CLT-1:0]    clt_req_ready;
    logic [NUM_CLT*AW-1:0] clt_req_addr;
    logic [NUM_CLT*LW-1:0] clt_req_len;
    logic                  mem_req_valid;
    logic                  mem_req_ready = 1'b1;
    logic [AW-1:0]         mem_req_addr;
    logic [LW-1:0]         mem_req_len;
    logic [CLT_IDW-1:0]    mem_req_id;
    logic                  rsp_done_valid;
    logic [CLT_IDW-1:0]    rsp_done_id;
    logic [NUM_CLT-1:0]    outs_full;
    logic                  err_underflow;

    logic       auto_rsp = 1'b0;
    logic       a_v = 1'b0;
    logic [1:0] a_id = '0;
    logic       m_v = 1'b0;
    logic [1:0] m_id = '0;

    int checks = 0;
    int errors = 0;
    int exp_q[$];

    assign rsp_done_valid = a_v | m_v;
    assign rsp_done_id    = a_v ? a_id : m_id;

    mcif_wrr_sched4 #(.AW(AW), .LW(LW), .WW(WW), .MAX_OUTS(MO)) dut (
        .clk            (clk),
        .rst            (rst),
        .cfg_weight     (cfg_weight),
        .clt_req_valid  (clt_req_valid),
        .clt_req_ready  (clt_req_ready),
        .clt_req_addr   (clt_req_addr),
        .clt_req_len    (clt_req_len),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_req_len    (mem_req_len),
        .mem_req_id     (mem_req_id),
        .rsp_done_valid (rsp_done_valid),
        .rsp_done_id    (rsp_done_id),
        .outs_full      (outs_full),
        .err_underflow  (err_underflow)
    );

    always #5 clk = ~clk;

    function automatic logic [AW-1:0] addr_of(int i);
        return 32'hA000_0000 + 32'(i) * 32'h100;
    endfunction

    function automatic logic [LW-1:0] len_of(int i);
        return 8'h10 + 8'(i);
    endfunction

    assign clt_req_addr = {addr_of(3), addr_of(2), addr_of(1), addr_of(0)};
    assign clt_req_len  = {len_of(3), len_of(2), len_of(1), len_of(0)};

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_ids(input int ids[]);
        foreach (ids[k]) exp_q.push_back(ids[k]);
    endtask

    // Scoreboard monitor: every accepted downstream request pops one entry.
    initial forever begin
        @(negedge clk);
        if (!rst && mem_req_valid && mem_req_ready) begin
            int e;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_req: got id %0d expected none",
                         mem_req_id);
            end else begin
                e = exp_q.pop_front();
                check("mem_req_id", 32'(mem_req_id), 32'(e));
                check("mem_req_addr", mem_req_addr, addr_of(e));
                check("mem_req_len", 32'(mem_req_len), 32'(len_of(e)));
            end
        end
    end

    // Completion responder: returns each accepted request one cycle later.
    initial forever begin
        logic       pend;
        logic [1:0] pid;
        @(negedge clk);
        pend = auto_rsp && mem_req_valid && mem_req_ready;
        pid  = mem_req_id;
        @(posedge clk);
        #1;
        a_v  = pend;
        a_id = pid;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_mem_valid", 32'(mem_req_valid), 0);
        check("rst_mem_addr", mem_req_addr, 0);
        check("rst_mem_id", 32'(mem_req_id), 0);
        check("rst_outs_full", 32'(outs_full), 0);
        check("rst_err", 32'(err_underflow), 0);
        check("rst_ready", 32'(clt_req_ready), 0);

        // Equal weights: strict rotation from client 0.
        auto_rsp = 1'b1;
        push_ids('{0, 1, 2, 3, 0, 1, 2, 3});
        clt_req_valid = 4'hF;
        #1;
        check("t1_first_ready", 32'(clt_req_ready), 32'h1);
        step();
        check("t1_latency_valid", 32'(mem_req_valid), 1);
        repeat (7) step();
        clt_req_valid = '0;
        repeat (6) step();

        // Weights {3,1,2,1}.
        cfg_weight = 16'h1213;
        push_ids('{0, 0, 0, 1, 2, 2, 3, 0, 0, 0, 1, 2, 2, 3});
        clt_req_valid = 4'hF;
        repeat (14) step();
        clt_req_valid = '0;
        repeat (6) step();
        auto_rsp = 1'b0;
        repeat (3) step();
        check("t2_drained_full", 32'(outs_full), 0);
        check("t2_err", 32'(err_underflow), 0);

        // Outstanding limit on client 1.
        push_ids('{1, 1, 1, 1, 1, 1, 1, 1, 1});
        clt_req_valid = 4'b0010;
        repeat (8) step();
        check("t3_ready_at_limit", 32'(clt_req_ready), 0);
        check("t3_full_at_limit", 32'(outs_full), 32'h2);
        m_v  = 1'b1;
        m_id = 2'd1;
        step();
        m_v = 1'b0;
        check("t3_ready_after_rsp", 32'(clt_req_ready), 32'h2);
        check("t3_full_after_rsp", 32'(outs_full), 0);
        step();
        check("t3_ready_refull", 32'(clt_req_ready), 0);
        check("t3_full_refull", 32'(outs_full), 32'h2);
        clt_req_valid = '0;
        m_v = 1'b1;
        repeat (8) step();
        m_v = 1'b0;
        check("t3_full_cleared", 32'(outs_full), 0);
        check("t3_err", 32'(err_underflow), 0);

        // Downstream stall holds the registered request.
        cfg_weight    = 16'h1111;
        mem_req_ready = 1'b0;
        clt_req_valid = 4'hF;
        push_ids('{2, 3});
        step();
        for (int k = 0; k < 5; k++) begin
            check("t4_stall_valid", 32'(mem_req_valid), 1);
            check("t4_stall_id", 32'(mem_req_id), 2);
            check("t4_stall_addr", mem_req_addr, addr_of(2));
            check("t4_stall_len", 32'(mem_req_len), 32'(len_of(2)));
            check("t4_stall_ready", 32'(clt_req_ready), 0);
            if (k < 4) step();
        end
        mem_req_ready = 1'b1;
        step();
        clt_req_valid = '0;
        step();

        // Clear leftovers on clients 2 and 3.
        m_v  = 1'b1;
        m_id = 2'd2;
        step();
        m_id = 2'd3;
        step();
        m_v = 1'b0;
        check("t5_pre_err", 32'(err_underflow), 0);
        check("t5_pre_cnt2", 32'(dut.cnt[2]), 0);
        check("t5_pre_cnt3", 32'(dut.cnt[3]), 0);

        // Same-cycle issue and completion, then underflow.
        push_ids('{2, 2});
        clt_req_valid = 4'b0100;
        step();
        m_v  = 1'b1;
        m_id = 2'd2;
        step();
        m_v = 1'b0;
        clt_req_valid = '0;
        check("t5_cnt2_unchanged", 32'(dut.cnt[2]), 1);
        check("t5_err_clear", 32'(err_underflow), 0);
        m_v  = 1'b1;
        m_id = 2'd3;
        step();
        m_v = 1'b0;
        check("t5_underflow", 32'(err_underflow), 1);
        check("t5_cnt3_zero", 32'(dut.cnt[3]), 0);
        step();

        // Reset mid-operation drops the pending request.
        mem_req_ready = 1'b0;
        clt_req_valid = 4'b0001;
        step();
        clt_req_valid = '0;
        check("t6_pending", 32'(mem_req_valid), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t6_valid_cleared", 32'(mem_req_valid), 0);
        check("t6_full_cleared", 32'(outs_full), 0);
        check("t6_err_cleared", 32'(err_underflow), 0);
        check("t6_cnt0_cleared", 32'(dut.cnt[0]), 0);
        check("t6_cnt2_cleared", 32'(dut.cnt[2]), 0);
        mem_req_ready = 1'b1;
        clt_req_valid = 4'hF;
        push_ids('{0});
        #1;
        check("t6_first_ready", 32'(clt_req_ready), 32'h1);
        step();
        clt_req_valid = '0;

        for (int k = 0; k < 20 && exp_q.size() != 0; k++) step();
        repeat (2) step();
        check("queue_empty", 32'(exp_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
